// File: rtl/hazard_controller_if.sv
// Hazard unit bundle: pipeline register/control taps in, stall/flush/forward controls and
// performance counters out. The core drives through master; the hazard controller uses slave.
interface hazard_controller_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic        MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemTimeout;
  logic [31:0] LoadStallCnt, MemStallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
           MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MemTimeout,
           LoadStallCnt, MemStallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
           MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MemTimeout,
           LoadStallCnt, MemStallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, branch flush and a
// data-memory wait FSM with timeout. Define HAZARD_PERF_EN to build the performance counters.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic               clk,
  input logic               clr,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

  state_e     r_state, w_state_next;
  logic [7:0] r_wait_cnt, w_wait_cnt_next;

  logic w_lw_stall, w_mem_stall, w_error;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_d, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Memory stage is newer than writeback, so it wins when both match.
  always_comb begin
    w_fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
      w_fwd_a = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
      w_fwd_a = 2'b01;
    end
    w_fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
      w_fwd_b = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
      w_fwd_b = 2'b01;
    end
  end

  assign w_lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_mem_stall = hz.MemReqM && !hz.MemReadyM;
  assign w_error     = (r_state == StError);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= StRun;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // WaitCnt counts not-ready cycles already seen, including the one that left StRun.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      StRun: begin
        if (w_mem_stall) begin
          w_state_next    = StMemWait;
          w_wait_cnt_next = 8'd1;
        end else begin
          w_wait_cnt_next = 8'd0;
        end
      end
      StMemWait: begin
        if (!w_mem_stall) begin
          w_state_next    = StRun;
          w_wait_cnt_next = 8'd0;
        end else if (r_wait_cnt == LastWait) begin
          w_state_next    = StError;
          w_wait_cnt_next = 8'd0;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end
      StError: begin
        w_state_next    = StError;
        w_wait_cnt_next = 8'd0;
      end
      default: begin
        w_state_next    = StRun;
        w_wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Freeze beats redirect beats load bubble; a taken branch discards the load-use pair anyway.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (w_error || w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else if (hz.PCSrcE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign hz.StallF     = w_stall_f;
  assign hz.StallD     = w_stall_d;
  assign hz.StallE     = w_stall_e;
  assign hz.StallM     = w_stall_m;
  assign hz.FlushD     = w_flush_d;
  assign hz.FlushE     = w_flush_e;
  assign hz.ForwardAE  = w_fwd_a;
  assign hz.ForwardBE  = w_fwd_b;
  assign hz.MemTimeout = w_error;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_load_cnt, r_mem_cnt, r_flush_cnt;
  logic        w_inc_load, w_inc_mem, w_inc_flush;

  assign w_inc_mem   = !w_error && w_mem_stall;
  assign w_inc_flush = !w_error && !w_mem_stall && hz.PCSrcE;
  assign w_inc_load  = !w_error && !w_mem_stall && !hz.PCSrcE && w_lw_stall;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_load_cnt  <= 32'd0;
      r_mem_cnt   <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_inc_load)  r_load_cnt  <= r_load_cnt + 32'd1;
      if (w_inc_mem)   r_mem_cnt   <= r_mem_cnt + 32'd1;
      if (w_inc_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.LoadStallCnt = r_load_cnt;
  assign hz.MemStallCnt  = r_mem_cnt;
  assign hz.FlushCnt     = r_flush_cnt;
`else
  assign hz.LoadStallCnt = 32'd0;
  assign hz.MemStallCnt  = 32'd0;
  assign hz.FlushCnt     = 32'd0;
`endif

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64 (range 2..255): consecutive data-memory not-ready cycles tolerated before the timeout error.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge; clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: Rs1D, Rs2D  in  5 each  decode-stage source registers; Rs1E, Rs2E, RdE  in  5 each  execute-stage registers.
REQ-004 SHALL have ports: RdM, RdW  in  5 each  memory/writeback destinations; RegWriteM, RegWriteW  in  1 each  write enables.
REQ-005 SHALL have ports: ResultSrcE  in  2  execute result select (2'b01 = load); PCSrcE  in  1  taken branch/jump in E.
REQ-006 SHALL have ports: MemReqM  in  1  data-memory access in M; MemReadyM  in  1  data memory completes access this cycle.
REQ-007 SHALL have ports: StallF, StallD, StallE, StallM  out  1 each  hold stage register; FlushD, FlushE  out  1 each  clear stage register (FlushE drives the ID/EX clr).
REQ-008 SHALL have ports: ForwardAE, ForwardBE  out  2 each  ALU operand select (00 register file, 01 writeback, 10 memory).
REQ-009 SHALL have ports: MemTimeout  out  1  sticky error; LoadStallCnt, MemStallCnt, FlushCnt  out  32 each  performance counters.

Function
REQ-010 ForwardAE SHALL be 10 when RegWriteM && RdM!=0 && RdM==Rs1E, else 01 when RegWriteW && RdW!=0 && RdW==Rs1E, else 00; ForwardBE identical using Rs2E; combinational, memory stage wins.
REQ-011 lwStall SHALL be ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-012 memStall SHALL be MemReqM && !MemReadyM.
REQ-013 FSM states SHALL be RUN, MEMWAIT, ERROR, plus 8-bit WaitCnt.
REQ-014 RUN: memStall -> MEMWAIT with WaitCnt=1; otherwise stay, WaitCnt=0.
REQ-015 MEMWAIT: !memStall -> RUN, WaitCnt=0; memStall && WaitCnt==MEM_TIMEOUT-1 -> ERROR; else WaitCnt+1.
REQ-016 ERROR SHALL be exited only by clr; MemTimeout=1 while in ERROR.
REQ-017 Priority, combinational, same cycle as cause: ERROR > memStall > PCSrcE > lwStall.
REQ-018 ERROR or memStall: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0.
REQ-019 PCSrcE (no higher cause): FlushD=FlushE=1, all stalls 0; redirect never blocked even if lwStall also true.
REQ-020 lwStall only: StallF=StallD=1, FlushE=1, StallE=StallM=0, FlushD=0 (one bubble per detection).
REQ-021 No cause: all stall/flush outputs 0.
REQ-022 Forwarding outputs SHALL remain valid in every state, including ERROR.

Reset
REQ-023 On clr at clk edge: state=RUN, WaitCnt=0, MemTimeout=0, all counters 0.
REQ-024 clr mid-MEMWAIT or in ERROR SHALL return to RUN next cycle; stall/flush outputs then follow inputs combinationally.

Configuration
REQ-025 Macro HAZARD_PERF_EN: defined -> LoadStallCnt, MemStallCnt, FlushCnt increment (wrap at 2^32) on each cycle where REQ-020, REQ-018 (memStall, not ERROR), REQ-019 respectively apply.
REQ-026 Undefined -> counter ports present, driven constant 0, no counter flops.

Verification
REQ-027 lw x5 in E (ResultSrcE=01, RdE=5), Rs1D=5 -> StallF=StallD=FlushE=1 one cycle; next cycle all 0.
REQ-028 RdM=3, RegWriteM=1, RdW=3, RegWriteW=1, Rs1E=3 -> ForwardAE=10; RdM=0 instead -> 01; RdW=0 also -> 00.
REQ-029 MemReqM=1, MemReadyM=0 three cycles then 1 -> all four stalls 1 for three cycles, 0 on fourth, state RUN, MemTimeout=0.
REQ-030 MEM_TIMEOUT=4, MemReadyM held 0 -> ERROR after 4 not-ready cycles, MemTimeout=1, stays until clr, then 0 next cycle.
REQ-031 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0; with memStall also 1 -> stalls 1, flushes 0.
REQ-032 With HAZARD_PERF_EN: one load stall, 3-cycle memory wait, one branch -> LoadStallCnt=1, MemStallCnt=3, FlushCnt=1; without it all read 0.
